// File: rtl/frame_buffer_arbiter.sv
// Frame BRAM arbiter for the face-detection engine.
// Port 0 (imager writer) has strict priority; ports 1 (rescaler reader) and
// 2 (overlay read-modify-write) share the remaining bandwidth round-robin
// with burst locking and a burst-length cap. Read data is routed back to the
// issuing port through a tag pipeline matched to the BRAM read latency.
module frame_buffer_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 12,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, OWN_0, OWN_1, OWN_2} state_e;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST - 1);

  state_e            state_q, state_d;
  logic [1:0]        rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [2:0]        tag_q [RD_LAT];
  logic [1:0]        owner;
  logic [2:0]        rd_tag;
  logic [2:0]        ret_tag;

  // Fixed priority for port 0, then the port 1/2 tie broken against rr_last.
  function automatic state_e pick(input logic [2:0] r, input logic [1:0] last);
    if (r[0]) return OWN_0;
    if (r[1] && r[2]) return (last == 2'd2) ? OWN_1 : OWN_2;
    if (r[1]) return OWN_1;
    if (r[2]) return OWN_2;
    return IDLE;
  endfunction

  // Decode the registered owner into grant vector and port index.
  always_comb begin
    gnt   = 3'b000;
    owner = 2'd0;
    case (state_q)
      OWN_0: begin gnt = 3'b001; owner = 2'd0; end
      OWN_1: begin gnt = 3'b010; owner = 2'd1; end
      OWN_2: begin gnt = 3'b100; owner = 2'd2; end
      default: ;
    endcase
  end

  assign busy   = |gnt;
  assign mem_en = |(gnt & req);

  // Steer the owner's request onto the BRAM port; write is suppressed when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      OWN_0: begin
        mem_we    = mem_en & we[0];
        mem_addr  = addr[0 +: ADDR_W];
        mem_wdata = wdata[0 +: DATA_W];
      end
      OWN_1: begin
        mem_we    = mem_en & we[1];
        mem_addr  = addr[ADDR_W +: ADDR_W];
        mem_wdata = wdata[DATA_W +: DATA_W];
      end
      OWN_2: begin
        mem_we    = mem_en & we[2];
        mem_addr  = addr[2*ADDR_W +: ADDR_W];
        mem_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // Next owner: hold, release, preempt by port 0, or switch at the burst cap.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE:  state_d = pick(req, rr_last_q);
      OWN_0: if (!req[0]) state_d = pick(req, rr_last_q);
      OWN_1: begin
        if (!req[1])                                   state_d = pick(req, rr_last_q);
        else if (req[0])                               state_d = OWN_0;
        else if (req[2] && mem_en && burst_cnt_q == CAP) state_d = OWN_2;
      end
      OWN_2: begin
        if (!req[2])                                   state_d = pick(req, rr_last_q);
        else if (req[0])                               state_d = OWN_0;
        else if (req[1] && mem_en && burst_cnt_q == CAP) state_d = OWN_1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      // Any grant change starts a fresh burst.
      burst_cnt_d = '0;
      if (state_q == OWN_1) rr_last_d = 2'd1;
      if (state_q == OWN_2) rr_last_d = 2'd2;
    end else if (mem_en && burst_cnt_q != CAP) begin
      // Saturate so an unopposed burst switches on its next access once opposed.
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_last_q   <= 2'd2;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // ---- access cycle -> read tag pipeline (RD_LAT stages) ----
  assign rd_tag = {mem_en & ~mem_we, owner};

  // Shift the read tags alongside the BRAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= 3'b000;
    end else begin
      tag_q[0] <= rd_tag;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // ---- return stage: tag lines up with mem_rdata ----
  assign ret_tag = tag_q[RD_LAT-1];
  assign rvalid  = ret_tag[2] ? (3'b001 << ret_tag[1:0]) : 3'b000;
  assign rdata   = ret_tag[2] ? mem_rdata : '0;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: a cycle table for basic
// read/write traffic plus directed sequences for arbitration corner cases.
module tb_frame_buffer_arbiter;

  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 12;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;

  logic                clk;
  logic                rst_n;
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;

  int checks = 0;
  int errors = 0;

  frame_buffer_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: content is a fixed function of the address, RD_LAT-cycle read.
  function automatic logic [DATA_W-1:0] f(input logic [ADDR_W-1:0] a);
    return DATA_W'(a * 3 + 1);
  endfunction

  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= (mem_en && !mem_we) ? f(mem_addr) : DATA_W'(12'hBAD);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  typedef struct {
    logic [2:0]        req;
    logic [2:0]        we;
    logic [ADDR_W-1:0] a0, a1, a2;
    logic [2:0]        exp_gnt;
    logic              exp_en;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [2:0]        exp_rv;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w,
                              input int a0, input int a1, input int a2,
                              input logic [2:0] eg, input logic ee, input logic ew,
                              input int ea, input logic [2:0] erv,
                              input logic [DATA_W-1:0] erd);
    vec_t v;
    v.req = r; v.we = w;
    v.a0 = ADDR_W'(a0); v.a1 = ADDR_W'(a1); v.a2 = ADDR_W'(a2);
    v.exp_gnt = eg; v.exp_en = ee; v.exp_we = ew; v.exp_addr = ADDR_W'(ea);
    v.exp_rv = erv; v.exp_rd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] w, input int a0,
                       input int a1, input int a2, input int w0);
    req   = r;
    we    = w;
    addr  = {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    wdata = {DATA_W'(0), DATA_W'(0), DATA_W'(w0)};
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Port 1 reads 5,6,7 then releases; port 2 writes once.
    tbl[0]  = mk(3'b010, 3'b000, 0, 5, 0, 3'b000, 0, 0, 0, 3'b000, '0);
    tbl[1]  = mk(3'b010, 3'b000, 0, 5, 0, 3'b010, 1, 0, 5, 3'b000, '0);
    tbl[2]  = mk(3'b010, 3'b000, 0, 6, 0, 3'b010, 1, 0, 6, 3'b000, '0);
    tbl[3]  = mk(3'b010, 3'b000, 0, 7, 0, 3'b010, 1, 0, 7, 3'b010, f(5));
    tbl[4]  = mk(3'b000, 3'b000, 0, 0, 0, 3'b010, 0, 0, 0, 3'b010, f(6));
    tbl[5]  = mk(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 3'b010, f(7));
    tbl[6]  = mk(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, '0);
    tbl[7]  = mk(3'b100, 3'b100, 0, 0, 9, 3'b000, 0, 0, 0, 3'b000, '0);
    tbl[8]  = mk(3'b100, 3'b100, 0, 0, 9, 3'b100, 1, 1, 9, 3'b000, '0);
    tbl[9]  = mk(3'b000, 3'b000, 0, 0, 0, 3'b100, 0, 0, 0, 3'b000, '0);
    tbl[10] = mk(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, '0);

    reset_dut();
    #1;
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset rvalid", 32'(rvalid), 32'd0);
    chk("reset rdata", 32'(rdata), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].we, int'(tbl[i].a0), int'(tbl[i].a1), int'(tbl[i].a2), 0);
      #1;
      chk($sformatf("tbl[%0d] gnt", i), 32'(gnt), 32'(tbl[i].exp_gnt));
      chk($sformatf("tbl[%0d] busy", i), 32'(busy), 32'(|tbl[i].exp_gnt));
      chk($sformatf("tbl[%0d] mem_en", i), 32'(mem_en), 32'(tbl[i].exp_en));
      chk($sformatf("tbl[%0d] mem_we", i), 32'(mem_we), 32'(tbl[i].exp_we));
      if (tbl[i].exp_en)
        chk($sformatf("tbl[%0d] mem_addr", i), 32'(mem_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("tbl[%0d] rvalid", i), 32'(rvalid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv != 3'b000)
        chk($sformatf("tbl[%0d] rdata", i), 32'(rdata), 32'(tbl[i].exp_rd));
    end

    // Ports 1 and 2 both streaming: grants alternate in bursts of MAX_BURST.
    reset_dut();
    for (int c = 0; c < 17; c++) begin
      logic [2:0] eg;
      @(negedge clk);
      drive(3'b110, 3'b000, 0, 11, 22, 0);
      #1;
      if (c == 0) eg = 3'b000;
      else eg = (((c - 1) / MAX_BURST) % 2 == 0) ? 3'b010 : 3'b100;
      chk($sformatf("rr c%0d gnt", c), 32'(gnt), 32'(eg));
      if (c != 0) chk($sformatf("rr c%0d mem_en", c), 32'(mem_en), 32'd1);
    end

    // Port 2 mid-burst preempted by port 0; port 0 writes 20 pixels.
    reset_dut();
    @(negedge clk); drive(3'b100, 3'b000, 0, 0, 60, 0); #1;
    chk("pre c0 gnt", 32'(gnt), 32'd0);
    @(negedge clk); drive(3'b100, 3'b000, 0, 0, 60, 0); #1;
    chk("pre c1 gnt", 32'(gnt), 32'b100);
    @(negedge clk); drive(3'b100, 3'b000, 0, 0, 61, 0); #1;
    chk("pre c2 gnt", 32'(gnt), 32'b100);
    @(negedge clk); drive(3'b111, 3'b001, 100, 70, 62, 200); #1;
    chk("pre c3 gnt", 32'(gnt), 32'b100);
    chk("pre c3 mem_en", 32'(mem_en), 32'd1);
    chk("pre c3 mem_addr", 32'(mem_addr), 32'd62);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(3'b111, 3'b001, 100 + i, 70, 63, 200 + i); #1;
      chk($sformatf("p0 w%0d gnt", i), 32'(gnt), 32'b001);
      chk($sformatf("p0 w%0d mem_we", i), 32'(mem_we), 32'd1);
      chk($sformatf("p0 w%0d mem_addr", i), 32'(mem_addr), 32'(100 + i));
      chk($sformatf("p0 w%0d mem_wdata", i), 32'(mem_wdata), 32'(200 + i));
    end
    @(negedge clk); drive(3'b100, 3'b000, 0, 0, 64, 0); #1;
    chk("p0 release gnt", 32'(gnt), 32'b001);
    chk("p0 release mem_en", 32'(mem_en), 32'd0);
    @(negedge clk); drive(3'b100, 3'b000, 0, 0, 64, 0); #1;
    chk("p2 regain gnt", 32'(gnt), 32'b100);
    chk("p2 regain mem_addr", 32'(mem_addr), 32'd64);

    // Port 1 read, then port 0 preempts with writes: read still returns.
    reset_dut();
    @(negedge clk); drive(3'b010, 3'b000, 0, 33, 0, 0); #1;
    chk("rdp c0 gnt", 32'(gnt), 32'd0);
    @(negedge clk); drive(3'b011, 3'b001, 40, 33, 0, 5); #1;
    chk("rdp c1 gnt", 32'(gnt), 32'b010);
    chk("rdp c1 mem_addr", 32'(mem_addr), 32'd33);
    @(negedge clk); drive(3'b001, 3'b001, 40, 0, 0, 5); #1;
    chk("rdp c2 gnt", 32'(gnt), 32'b001);
    chk("rdp c2 mem_we", 32'(mem_we), 32'd1);
    chk("rdp c2 rvalid", 32'(rvalid), 32'd0);
    @(negedge clk); drive(3'b001, 3'b001, 41, 0, 0, 6); #1;
    chk("rdp c3 rvalid", 32'(rvalid), 32'b010);
    chk("rdp c3 rdata", 32'(rdata), 32'(f(33)));
    @(negedge clk); drive(3'b000, 3'b000, 0, 0, 0, 0); #1;
    chk("rdp c4 rvalid", 32'(rvalid), 32'd0);
    @(negedge clk); #1;
    chk("rdp c5 rvalid", 32'(rvalid), 32'd0);

    // Async reset with two reads in flight for port 2.
    reset_dut();
    @(negedge clk); drive(3'b100, 3'b000, 0, 0, 50, 0);
    @(negedge clk); drive(3'b100, 3'b000, 0, 0, 50, 0); #1;
    chk("ar c1 gnt", 32'(gnt), 32'b100);
    @(negedge clk); drive(3'b100, 3'b000, 0, 0, 51, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 0, 0, 0, 0);
    #1;
    chk("ar gnt", 32'(gnt), 32'd0);
    chk("ar rvalid", 32'(rvalid), 32'd0);
    chk("ar mem_en", 32'(mem_en), 32'd0);
    chk("ar busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("ar post c%0d rvalid", c), 32'(rvalid), 32'd0);
    end
    @(negedge clk); drive(3'b110, 3'b000, 0, 1, 2, 0); #1;
    chk("ar tie c0 gnt", 32'(gnt), 32'd0);
    @(negedge clk); #1;
    chk("ar tie c1 gnt", 32'(gnt), 32'b010);

    // Idle: no requests for 10 cycles.
    @(negedge clk); drive(3'b000, 3'b000, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk($sformatf("idle c%0d gnt", c), 32'(gnt), 32'd0);
      chk($sformatf("idle c%0d busy", c), 32'(busy), 32'd0);
      chk($sformatf("idle c%0d mem_en", c), 32'(mem_en), 32'd0);
    end
    chk("idle burst_cnt", 32'(dut.burst_cnt_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
